// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared FSM encodings and pipeline control bundle for the
//               ARM pipeline hazard sequencer and its stage registers.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int C_RA_W = 4;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REL      = 2'd2
    } state_t;

    // One definition of the per-register hold/clear strobes
    typedef struct packed {
        logic freeze_pc;
        logic if_id_freeze;
        logic if_id_flush;
        logic id_ex_freeze;
        logic id_ex_flush;
        logic ex_mem_freeze;
        logic mem_wb_flush;
    } pipe_ctrl_t;

endpackage
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational RAW comparator. With forwarding only a load in
//               EX stalls; without it any EX/MEM destination match stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect #(
    parameter int RA_W   = 4,
    parameter bit FWD_EN = 1'b1
) (
    input  logic [RA_W-1:0] id_src1,
    input  logic [RA_W-1:0] id_src2,
    input  logic            id_use1,
    input  logic            id_use2,
    input  logic [RA_W-1:0] exe_dest,
    input  logic            exe_wb_en,
    input  logic            exe_mem_r_en,
    input  logic [RA_W-1:0] mem_dest,
    input  logic            mem_wb_en,
    output logic            stall
);

    logic w_ex_hit1;
    logic w_ex_hit2;
    logic w_mem_hit1;
    logic w_mem_hit2;

    assign w_ex_hit1  = id_use1 && exe_wb_en && (id_src1 == exe_dest);
    assign w_ex_hit2  = id_use2 && exe_wb_en && (id_src2 == exe_dest);
    assign w_mem_hit1 = id_use1 && mem_wb_en && (id_src1 == mem_dest);
    assign w_mem_hit2 = id_use2 && mem_wb_en && (id_src2 == mem_dest);

    assign stall = FWD_EN ? (exe_mem_r_en && (w_ex_hit1 || w_ex_hit2))
                          : (w_ex_hit1 || w_ex_hit2 || w_mem_hit1 || w_mem_hit2);

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Stall/flush sequencer arbitrating cache wait, taken branch and
//               RAW hazards. Optional counters: define HAZARD_PERF_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W   = C_RA_W,
    parameter bit FWD_EN = 1'b1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_src1,
    input  logic [RA_W-1:0]  id_src2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic [RA_W-1:0]  exe_dest,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [RA_W-1:0]  mem_dest,
    input  logic             mem_wb_en,
    input  logic             exe_branch_taken,
    input  logic             mem_req,
    input  logic             cache_ready,
    output logic             freeze_pc,
    output logic             if_id_freeze,
    output logic             if_id_flush,
    output logic             id_ex_freeze,
    output logic             id_ex_flush,
    output logic             ex_mem_freeze,
    output logic             mem_wb_flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] perf_stall,
    output logic [CNT_W-1:0] perf_flush,
    output logic [CNT_W-1:0] perf_mwait,
    input  logic             perf_clr
);

    state_t     r_state;
    state_t     w_state_nxt;
    pipe_ctrl_t w_ctrl;
    logic       w_raw_stall;
    logic       w_wait;
    logic       w_wait_act;
    logic       w_branch_act;
    logic       w_stall_act;

    hazard_detect #(
        .RA_W   (RA_W),
        .FWD_EN (FWD_EN)
    ) u_hazard_detect (
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_use1      (id_use1),
        .id_use2      (id_use2),
        .exe_dest     (exe_dest),
        .exe_wb_en    (exe_wb_en),
        .exe_mem_r_en (exe_mem_r_en),
        .mem_dest     (mem_dest),
        .mem_wb_en    (mem_wb_en),
        .stall        (w_raw_stall)
    );

    // A miss is visible in RUN the same cycle it is requested
    assign w_wait       = (r_state == ST_MEM_WAIT) ||
                          ((r_state == ST_RUN) && mem_req && !cache_ready);
    assign w_wait_act   = !rst && w_wait;
    assign w_branch_act = !rst && !w_wait && exe_branch_taken;
    assign w_stall_act  = !rst && !w_wait && !exe_branch_taken && w_raw_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ctrl      = '0;
        case (r_state)
            ST_RUN:      if (mem_req && !cache_ready) w_state_nxt = ST_MEM_WAIT;
            ST_MEM_WAIT: if (cache_ready)             w_state_nxt = ST_REL;
            ST_REL:                                   w_state_nxt = ST_RUN;
            default:                                  w_state_nxt = ST_RUN;
        endcase

        if (w_wait_act) begin
            w_ctrl.freeze_pc     = 1'b1;
            w_ctrl.if_id_freeze  = 1'b1;
            w_ctrl.id_ex_freeze  = 1'b1;
            w_ctrl.ex_mem_freeze = 1'b1;
            w_ctrl.mem_wb_flush  = 1'b1;
        end else if (w_branch_act) begin
            w_ctrl.if_id_flush   = 1'b1;
            w_ctrl.id_ex_flush   = 1'b1;
        end else if (w_stall_act) begin
            w_ctrl.freeze_pc     = 1'b1;
            w_ctrl.if_id_freeze  = 1'b1;
            w_ctrl.id_ex_flush   = 1'b1;
        end
    end

    assign freeze_pc     = w_ctrl.freeze_pc;
    assign if_id_freeze  = w_ctrl.if_id_freeze;
    assign if_id_flush   = w_ctrl.if_id_flush;
    assign id_ex_freeze  = w_ctrl.id_ex_freeze;
    assign id_ex_flush   = w_ctrl.id_ex_flush;
    assign ex_mem_freeze = w_ctrl.ex_mem_freeze;
    assign mem_wb_flush  = w_ctrl.mem_wb_flush;
    assign state_o       = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] r_perf_stall;
    logic [CNT_W-1:0] r_perf_flush;
    logic [CNT_W-1:0] r_perf_mwait;

    // Saturating counters; a clear takes precedence over any increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_mwait <= '0;
        end else if (perf_clr) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_mwait <= '0;
        end else begin
            if ((w_wait_act || w_stall_act) && (r_perf_stall != '1))
                r_perf_stall <= r_perf_stall + CNT_W'(1);
            if (w_branch_act && (r_perf_flush != '1))
                r_perf_flush <= r_perf_flush + CNT_W'(1);
            if (w_wait_act && (r_perf_mwait != '1))
                r_perf_mwait <= r_perf_mwait + CNT_W'(1);
        end
    end

    assign perf_stall = r_perf_stall;
    assign perf_flush = r_perf_flush;
    assign perf_mwait = r_perf_mwait;
`else
    logic w_unused_perf;
    assign w_unused_perf = perf_clr;
    assign perf_stall    = '0;
    assign perf_flush    = '0;
    assign perf_mwait    = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Directed self-checking bench; u0 has forwarding, u1 does not.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int C_RA_W  = 4;
    localparam int C_CNT_W = 16;
    // {freeze_pc, if_id_freeze, if_id_flush, id_ex_freeze, id_ex_flush, ex_mem_freeze, mem_wb_flush}
    localparam logic [6:0] C_ZERO = 7'b0000000;
    localparam logic [6:0] C_WAIT = 7'b1101011;
    localparam logic [6:0] C_BR   = 7'b0010100;
    localparam logic [6:0] C_LU   = 7'b1100100;

    logic              clk;
    logic              rst;
    logic [C_RA_W-1:0] id_src1, id_src2, exe_dest, mem_dest;
    logic              id_use1, id_use2, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic              exe_branch_taken, mem_req, cache_ready, perf_clr;

    logic              fpc0, ifz0, ifl0, idz0, idl0, exz0, mwl0;
    logic              fpc1, ifz1, ifl1, idz1, idl1, exz1, mwl1;
    logic [1:0]        st0, st1;
    logic [C_CNT_W-1:0] ps0, pf0, pm0, ps1, pf1, pm1;

    logic [6:0] v0, v1;
    assign v0 = {fpc0, ifz0, ifl0, idz0, idl0, exz0, mwl0};
    assign v1 = {fpc1, ifz1, ifl1, idz1, idl1, exz1, mwl1};

    int total = 0;
    int bad   = 0;

    pipe_hazard_ctrl #(.RA_W(C_RA_W), .FWD_EN(1'b1), .CNT_W(C_CNT_W)) u0 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use1(id_use1), .id_use2(id_use2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .exe_branch_taken(exe_branch_taken),
        .mem_req(mem_req), .cache_ready(cache_ready),
        .freeze_pc(fpc0), .if_id_freeze(ifz0), .if_id_flush(ifl0),
        .id_ex_freeze(idz0), .id_ex_flush(idl0), .ex_mem_freeze(exz0),
        .mem_wb_flush(mwl0), .state_o(st0), .perf_stall(ps0),
        .perf_flush(pf0), .perf_mwait(pm0), .perf_clr(perf_clr)
    );

    pipe_hazard_ctrl #(.RA_W(C_RA_W), .FWD_EN(1'b0), .CNT_W(C_CNT_W)) u1 (
        .clk(clk), .rst(rst), .id_src1(id_src1), .id_src2(id_src2),
        .id_use1(id_use1), .id_use2(id_use2), .exe_dest(exe_dest),
        .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .mem_dest(mem_dest),
        .mem_wb_en(mem_wb_en), .exe_branch_taken(exe_branch_taken),
        .mem_req(mem_req), .cache_ready(cache_ready),
        .freeze_pc(fpc1), .if_id_freeze(ifz1), .if_id_flush(ifl1),
        .id_ex_freeze(idz1), .id_ex_flush(idl1), .ex_mem_freeze(exz1),
        .mem_wb_flush(mwl1), .state_o(st1), .perf_stall(ps1),
        .perf_flush(pf1), .perf_mwait(pm1), .perf_clr(perf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_src1 = '0; id_src2 = '0; id_use1 = 1'b0; id_use2 = 1'b0;
        exe_dest = '0; exe_wb_en = 1'b0; exe_mem_r_en = 1'b0;
        mem_dest = '0; mem_wb_en = 1'b0; exe_branch_taken = 1'b0;
        mem_req = 1'b0; cache_ready = 1'b0; perf_clr = 1'b0;
    endtask

    task automatic set_load_use();
        exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_r_en = 1'b1;
        id_src1 = 4'd3; id_use1 = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        #2;
        chk("rst_v0", {25'd0, v0}, {25'd0, C_ZERO});
        chk("rst_state", {30'd0, st0}, 32'd0);
        mem_req = 1'b1;
        #1;
        chk("rst_miss_gated", {25'd0, v0}, {25'd0, C_ZERO});
        mem_req = 1'b0;
        next_cyc();
        rst = 1'b0;

        // load-use stalls both variants, then clears once the bubble is in EX
        set_load_use();
        #1;
        chk("lu_v0", {25'd0, v0}, {25'd0, C_LU});
        chk("lu_v1", {25'd0, v1}, {25'd0, C_LU});
        next_cyc();
        exe_wb_en = 1'b0; exe_mem_r_en = 1'b0; exe_dest = '0;
        #1;
        chk("lu_bubble_v0", {25'd0, v0}, {25'd0, C_ZERO});

        // ALU result in EX: forwarded on u0, stall on u1
        clear_inputs();
        exe_dest = 4'd3; exe_wb_en = 1'b1; id_src2 = 4'd3; id_use2 = 1'b1;
        #1;
        chk("alu_v0", {25'd0, v0}, {25'd0, C_ZERO});
        chk("alu_v1", {25'd0, v1}, {25'd0, C_LU});

        // MEM-stage destination match
        clear_inputs();
        mem_dest = 4'd5; mem_wb_en = 1'b1; id_src1 = 4'd5; id_use1 = 1'b1;
        #1;
        chk("memhit_v0", {25'd0, v0}, {25'd0, C_ZERO});
        chk("memhit_v1", {25'd0, v1}, {25'd0, C_LU});
        id_use1 = 1'b0;
        #1;
        chk("memhit_nouse_v1", {25'd0, v1}, {25'd0, C_ZERO});
        next_cyc();

        // cache miss: ready low 4 cycles
        clear_inputs();
        mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("miss_v0_%0d", i), {25'd0, v0}, {25'd0, C_WAIT});
            chk($sformatf("miss_st_%0d", i), {30'd0, st0}, (i == 0) ? 32'd0 : 32'd1);
            next_cyc();
        end
        cache_ready = 1'b1;
        #1;
        chk("miss_ready_v0", {25'd0, v0}, {25'd0, C_WAIT});
        chk("miss_ready_v1", {25'd0, v1}, {25'd0, C_WAIT});
        chk("miss_ready_st", {30'd0, st0}, 32'd1);
        next_cyc();
        mem_req = 1'b0; cache_ready = 1'b0;
        #1;
        chk("rel_st", {30'd0, st0}, 32'd2);
        chk("rel_v0", {25'd0, v0}, {25'd0, C_ZERO});
        next_cyc();
        #1;
        chk("run_st", {30'd0, st0}, 32'd0);
        next_cyc();

        // branch held during a miss acts only in REL
        mem_req = 1'b1; exe_branch_taken = 1'b1;
        #1;
        chk("brmiss_c0", {25'd0, v0}, {25'd0, C_WAIT});
        next_cyc();
        #1;
        chk("brmiss_c1", {25'd0, v0}, {25'd0, C_WAIT});
        cache_ready = 1'b1;
        #1;
        chk("brmiss_c2", {25'd0, v0}, {25'd0, C_WAIT});
        next_cyc();
        mem_req = 1'b0; cache_ready = 1'b0;
        #1;
        chk("brmiss_rel_st", {30'd0, st0}, 32'd2);
        chk("brmiss_rel_v0", {25'd0, v0}, {25'd0, C_BR});
        next_cyc();
        exe_branch_taken = 1'b0;
        #1;
        chk("brmiss_after", {25'd0, v0}, {25'd0, C_ZERO});

        // branch and load-use together: only the flushes
        set_load_use();
        exe_branch_taken = 1'b1;
        #1;
        chk("br_lu_v0", {25'd0, v0}, {25'd0, C_BR});
        chk("br_lu_v1", {25'd0, v1}, {25'd0, C_BR});
        clear_inputs();

        // stray cache_ready, and a hit completing in the request cycle
        cache_ready = 1'b1;
        #1;
        chk("stray_ready", {25'd0, v0}, {25'd0, C_ZERO});
        mem_req = 1'b1;
        #1;
        chk("hit_v0", {25'd0, v0}, {25'd0, C_ZERO});
        next_cyc();
        chk("hit_st", {30'd0, st0}, 32'd0);
        clear_inputs();
        next_cyc();

        // asynchronous reset between edges while in MEM_WAIT
        mem_req = 1'b1;
        next_cyc();
        #1;
        chk("arst_pre_st", {30'd0, st0}, 32'd1);
        rst = 1'b1;
        #1;
        chk("arst_v0", {25'd0, v0}, {25'd0, C_ZERO});
        chk("arst_st0", {30'd0, st0}, 32'd0);
        chk("arst_st1", {30'd0, st1}, 32'd0);
        chk("arst_ps", {16'd0, ps0}, 32'd0);
        chk("arst_pm", {16'd0, pm0}, 32'd0);
        mem_req = 1'b0;
        #1;
        rst = 1'b0;
        next_cyc();
        chk("arst_post_st", {30'd0, st0}, 32'd0);

`ifdef HAZARD_PERF_CNT_EN
        set_load_use();
        #1;
        next_cyc();
        chk("perf_stall_1", {16'd0, ps0}, 32'd1);
        perf_clr = 1'b1;
        next_cyc();
        chk("perf_clr_wins", {16'd0, ps0}, 32'd0);
        clear_inputs();
        exe_branch_taken = 1'b1;
        next_cyc();
        chk("perf_flush_1", {16'd0, pf0}, 32'd1);
        chk("perf_flush_nostall", {16'd0, ps0}, 32'd0);
        clear_inputs();
        mem_req = 1'b1;
        next_cyc();
        cache_ready = 1'b1;
        next_cyc();
        clear_inputs();
        chk("perf_mwait_2", {16'd0, pm0}, 32'd2);
        chk("perf_stall_2", {16'd0, ps0}, 32'd2);
        chk("perf_u1_mwait", {16'd0, pm1}, 32'd2);
`else
        chk("perf_off_ps", {16'd0, ps0}, 32'd0);
        chk("perf_off_pf", {16'd0, pf1}, 32'd0);
        chk("perf_off_pm", {16'd0, pm0}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
